found_collector: RTL and testbench

Downstream result stage for the NLFSR search array. It scans the per-module `found` flags round-robin and captures each hit's linear and nonlinear coefficient sets into a small record FIFO. It acknowledges the hitting module and streams each record as a byte sequence to the UART transmitter through a valid/ready handshake. It sits between the NLFSR array and the UART TX path in the top level.

---
 rtl/found_collector_pkg.sv | 30 +++
 rtl/record_fifo.sv | 58 +++++
 rtl/found_collector.sv | 205 ++++++++++++++++++++
 tb/tb_found_collector.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/found_collector_pkg.sv
// Shared types and helpers for the found_collector result stage.
// Holds the serializer state encoding, the CRC-8 polynomial, the record
// length calculation and the CRC-8 byte update used when
// FOUND_COLLECTOR_CRC_EN is defined.
package found_collector_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      CRC  = 2'd2
   } ser_state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // Record length in bytes: index byte, padded linear bytes, tap bytes.
   function automatic int rec_bytes(input int size, input int taps);
      return 1 + (size + 7) / 8 + taps;
   endfunction

   // MSB-first CRC-8 update of a running CRC with one data byte.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int b = 0; b < 8; b++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/record_fifo.sv
// Small synchronous FIFO of whole capture records.
// Read data is presented from the head entry without a read latency, so a
// pop and the use of its data happen in the same cycle. A write and a read
// may occur in the same cycle; fullness is judged before the read.
module record_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_fire;
   logic             rd_fire;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   assign rd_data = mem[rd_ptr_q[AW-1:0]];

   // Advance the read and write pointers on accepted operations.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer registers; clearing them empties the FIFO.
   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/found_collector.sv
// found_collector: round-robin scanner of NLFSR found flags, record FIFO
// and byte serializer towards the UART transmitter.
// Optional feature macro FOUND_COLLECTOR_CRC_EN appends a CRC-8 byte
// (poly 0x07, init 0x00, MSB-first) after each record.
import found_collector_pkg::*;

module found_collector #(
   parameter int NUM_OF_MODULES = 30,
   parameter int NUM_OF_TAPS    = 2,
   parameter int SIZE           = 24,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                                clk,
   input  logic                                res,
   input  logic [NUM_OF_MODULES-1:0]           found,
   input  logic [NUM_OF_MODULES*SIZE-1:0]      co_buf_lin,
   input  logic [NUM_OF_MODULES*NUM_OF_TAPS*8-1:0] co_buf_non,
   output logic [NUM_OF_MODULES-1:0]           ack,
   output logic [7:0]                          tx_data,
   output logic                                tx_valid,
   input  logic                                tx_ready,
   output logic [15:0]                         hit_count,
   output logic                                busy
);

   localparam int LB    = (SIZE + 7) / 8;
   localparam int REC   = rec_bytes(SIZE, NUM_OF_TAPS);
   localparam int RW    = REC * 8;
   localparam int NW    = NUM_OF_TAPS * 8;
   localparam int PTR_W = (NUM_OF_MODULES > 1) ? $clog2(NUM_OF_MODULES) : 1;
   localparam int CNT_W = $clog2(REC);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_OF_MODULES - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;

   logic [PTR_W-1:0]          ptr_q, ptr_d;
   logic [NUM_OF_MODULES-1:0] pending_q, pending_d;
   logic [NUM_OF_MODULES-1:0] ack_q, ack_d;
   logic [15:0]               hit_count_q, hit_count_d;

   logic                      sel_found;
   logic                      sel_pending;
   logic [SIZE-1:0]           sel_lin;
   logic [NW-1:0]             sel_non;
   logic                      capture;
   logic [RW-1:0]             rec_word;

   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_pop;
   logic [RW-1:0]             fifo_rdata;

   ser_state_e                state_q, state_d;
   logic [RW-1:0]             shift_q, shift_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
`ifdef FOUND_COLLECTOR_CRC_EN
   logic [7:0]                crc_q, crc_d;
`endif

   // Pick the flag, pending bit and coefficients of the module under the scan pointer.
   always_comb begin
      sel_found   = 1'b0;
      sel_pending = 1'b0;
      sel_lin     = '0;
      sel_non     = '0;
      for (int i = 0; i < NUM_OF_MODULES; i++) begin
         if (ptr_q == PTR_W'(i)) begin
            sel_found   = found[i];
            sel_pending = pending_q[i];
            sel_lin     = co_buf_lin[i*SIZE +: SIZE];
            sel_non     = co_buf_non[i*NW +: NW];
         end
      end
   end

   assign capture  = sel_found && !sel_pending && !fifo_full;
   assign rec_word = {8'(ptr_q), (LB*8)'(sel_lin), sel_non};

   // Scan pointer, pending tracking, ack pulse and hit counter updates.
   always_comb begin
      ptr_d       = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
      pending_d   = pending_q & found;
      ack_d       = '0;
      hit_count_d = hit_count_q;
      for (int i = 0; i < NUM_OF_MODULES; i++) begin
         if (capture && (ptr_q == PTR_W'(i))) begin
            pending_d[i] = 1'b1;
            ack_d[i]     = 1'b1;
         end
      end
      if (capture && (hit_count_q != 16'hFFFF)) hit_count_d = hit_count_q + 16'd1;
   end

   // Scanner and capture bookkeeping registers.
   always_ff @(posedge clk) begin
      if (res) begin
         ptr_q       <= '0;
         pending_q   <= '0;
         ack_q       <= '0;
         hit_count_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         pending_q   <= pending_d;
         ack_q       <= ack_d;
         hit_count_q <= hit_count_d;
      end
   end

   record_fifo #(
      .WIDTH (RW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .res     (res),
      .wr_en   (capture),
      .wr_data (rec_word),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Serializer next state: load a record, shift bytes out on accept, optional CRC trailer.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      fifo_pop = 1'b0;
`ifdef FOUND_COLLECTOR_CRC_EN
      crc_d    = crc_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               cnt_d    = '0;
               state_d  = SEND;
`ifdef FOUND_COLLECTOR_CRC_EN
               crc_d    = 8'h00;
`endif
            end
         end
         SEND: begin
            if (tx_ready) begin
               shift_d = shift_q << 8;
`ifdef FOUND_COLLECTOR_CRC_EN
               crc_d   = crc8_update(crc_q, shift_q[RW-1 -: 8]);
`endif
               if (cnt_q == CNT_LAST) begin
`ifdef FOUND_COLLECTOR_CRC_EN
                  state_d = CRC;
`else
                  state_d = IDLE;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
`ifdef FOUND_COLLECTOR_CRC_EN
         CRC: begin
            if (tx_ready) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Serializer registers; reset drops any partially sent record.
   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
`ifdef FOUND_COLLECTOR_CRC_EN
         crc_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
`ifdef FOUND_COLLECTOR_CRC_EN
         crc_q   <= crc_d;
`endif
      end
   end

   // Output byte follows the serializer state; zero whenever nothing is offered.
   always_comb begin
      tx_data = 8'h00;
      if (state_q == SEND) tx_data = shift_q[RW-1 -: 8];
`ifdef FOUND_COLLECTOR_CRC_EN
      else if (state_q == CRC) tx_data = crc_q;
`endif
   end

   assign tx_valid  = (state_q != IDLE);
   assign busy      = !fifo_empty || (state_q != IDLE);
   assign ack       = ack_q;
   assign hit_count = hit_count_q;

endmodule

// File: tb/tb_found_collector.sv
// Self-checking bench for found_collector. A reference model predicts the
// byte stream, ack counts and hit counter from the record rules; a monitor
// pops expected bytes as the DUT hands them over.
module tb_found_collector;

   localparam int N     = 30;
   localparam int TAPS  = 2;
   localparam int SIZE  = 24;
   localparam int DEPTH = 4;
   localparam int LB    = (SIZE + 7) / 8;
   localparam int REC   = 1 + LB + TAPS;

   logic                  clk;
   logic                  res;
   logic [N-1:0]          found;
   logic [N*SIZE-1:0]     co_buf_lin;
   logic [N*TAPS*8-1:0]   co_buf_non;
   logic [N-1:0]          ack;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [15:0]           hit_count;
   logic                  busy;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [7:0]   exp_q[$];
   int           ack_exp[N];
   int           ack_seen[N];
   int           model_hits = 0;
   int           mptr = 0;
   int           last_ptr = 0;
   int           rx_bytes = 0;
   int           ready_mode = 1;
   bit           quiet = 0;
   longint       lin_val[N];
   longint       non_val[N];

   logic         prev_valid = 0;
   logic         prev_ready = 0;
   logic [7:0]   prev_data = 0;
   logic [N-1:0] prev_ack = '0;

   found_collector #(
      .NUM_OF_MODULES (N),
      .NUM_OF_TAPS    (TAPS),
      .SIZE           (SIZE),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk        (clk),
      .res        (res),
      .found      (found),
      .co_buf_lin (co_buf_lin),
      .co_buf_non (co_buf_non),
      .ack        (ack),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .hit_count  (hit_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scan position model: one module per cycle, restarting at 0 after reset.
   always @(posedge clk) begin
      if (res) mptr <= 0;
      else     mptr <= (mptr + 1) % N;
   end

   // Receiver readiness: low, high or random, changed just after each edge.
   always begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       tx_ready = 1'b0;
         1:       tx_ready = 1'b1;
         default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: byte scoreboard, handshake stability and ack pulse width.
   always @(negedge clk) begin
      if (!res && !quiet) begin
         if (prev_valid && !prev_ready) begin
            checkOutput("tx_valid_held", tx_valid, 1);
            checkOutput("tx_data_held", tx_data, prev_data);
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("[TB] FAIL tx_unexpected_byte: got %02h, expected no byte", tx_data);
            end else begin
               checkOutput("tx_byte", tx_data, exp_q.pop_front());
            end
            rx_bytes++;
         end
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               ack_seen[i]++;
               checkOutput("ack_single_cycle", prev_ack[i], 0);
            end
         end
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_ack   = ack;
   end

   function automatic logic [7:0] crcRef(input logic [7:0] msg[$]);
      logic [7:0] crc;
      logic       fb;
      crc = 8'h00;
      foreach (msg[k]) begin
         for (int b = 7; b >= 0; b--) begin
            fb  = crc[7] ^ msg[k][b];
            crc = {crc[6:0], 1'b0};
            if (fb) crc = crc ^ 8'h07;
         end
      end
      return crc;
   endfunction

   task automatic pushRecord(input int idx);
      logic [7:0] rec[$];
      rec.push_back(8'(idx));
      for (int b = LB - 1; b >= 0; b--) rec.push_back(8'((lin_val[idx] >> (8 * b)) & 255));
      for (int t = TAPS - 1; t >= 0; t--) rec.push_back(8'((non_val[idx] >> (8 * t)) & 255));
      foreach (rec[k]) exp_q.push_back(rec[k]);
`ifdef FOUND_COLLECTOR_CRC_EN
      exp_q.push_back(crcRef(rec));
`endif
   endtask

   // Raise new hits; expected records follow scan order from the current position.
   task automatic applyStimulus(input logic [N-1:0] mask);
      int i;
      @(negedge clk);
      for (int m = 0; m < N; m++) begin
         co_buf_lin[m*SIZE +: SIZE]     = SIZE'(lin_val[m]);
         co_buf_non[m*TAPS*8 +: TAPS*8] = (TAPS*8)'(non_val[m]);
      end
      last_ptr = mptr;
      for (int k = 0; k < N; k++) begin
         i = (mptr + k) % N;
         if (mask[i]) begin
            pushRecord(i);
            ack_exp[i]++;
            if (model_hits < 65535) model_hits++;
         end
      end
      found = found | mask;
   endtask

   task automatic randomCoeffs(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            lin_val[i] = longint'($urandom) & ((64'd1 << SIZE) - 1);
            non_val[i] = longint'($urandom) & ((64'd1 << (TAPS * 8)) - 1);
         end
      end
   endtask

   function automatic logic [N-1:0] randomMask(input int k);
      logic [N-1:0] m;
      m = '0;
      while ($countones(m) < k) m[$urandom_range(0, N - 1)] = 1'b1;
      return m;
   endfunction

   task automatic waitDrain(input string name, input int bound);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < bound) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      checkOutput({name, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, "_busy"}, busy, 0);
      checkOutput({name, "_tx_valid"}, tx_valid, 0);
      checkOutput({name, "_hit_count"}, hit_count, model_hits);
      for (int i = 0; i < N; i++) checkOutput({name, "_ack_count"}, ack_seen[i], ack_exp[i]);
   endtask

   task automatic releaseAll();
      @(negedge clk);
      found = '0;
      repeat (4) @(negedge clk);
   endtask

   function automatic int sumAcks();
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += ack_seen[i];
      return s;
   endfunction

   // Global time limit so the run always ends.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ack_lat;
      int val_lat;
      int d;
      int acks_before;
      int hits_before;
      int base;
      int c;
      logic [N-1:0] m;

      res        = 1'b1;
      found      = '0;
      co_buf_lin = '0;
      co_buf_non = '0;
      tx_ready   = 1'b0;
      for (int i = 0; i < N; i++) begin
         ack_exp[i]  = 0;
         ack_seen[i] = 0;
         lin_val[i]  = 0;
         non_val[i]  = 0;
      end

      repeat (3) @(negedge clk);
      checkOutput("reset_ack", ack, 0);
      checkOutput("reset_tx_valid", tx_valid, 0);
      checkOutput("reset_tx_data", tx_data, 0);
      checkOutput("reset_hit_count", hit_count, 0);
      checkOutput("reset_busy", busy, 0);
      res = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] single hit on module 5");
      lin_val[5] = 64'hABCDEF;
      non_val[5] = 64'h1234;
      m = '0;
      m[5] = 1'b1;
      applyStimulus(m);
      d = (5 - last_ptr + N) % N;
      ack_lat = -1;
      val_lat = -1;
      for (int k = 1; k <= N + 8; k++) begin
         @(negedge clk);
         if (ack[5] && ack_lat < 0) ack_lat = k;
         if (tx_valid && val_lat < 0) val_lat = k;
      end
      checkOutput("ack_latency", ack_lat, d + 1);
      checkOutput("ack_to_tx_valid", val_lat - ack_lat, 1);
      waitDrain("single", 200);
      repeat (60) @(negedge clk);
      checkIdle("single_held");

      $display("[TB] module 5 drops and rises again");
      @(negedge clk);
      found[5] = 1'b0;
      repeat (3) @(negedge clk);
      applyStimulus(m);
      waitDrain("repeat", 200);
      checkIdle("repeat");
      releaseAll();

      $display("[TB] modules 0, 29 and 7 together");
      m = '0;
      m[0] = 1'b1;
      m[29] = 1'b1;
      m[7] = 1'b1;
      randomCoeffs(m);
      applyStimulus(m);
      waitDrain("triple", 300);
      checkIdle("triple");
      releaseAll();

      $display("[TB] six hits while the receiver stalls");
      ready_mode = 0;
      acks_before = sumAcks();
      hits_before = model_hits;
      m = randomMask(6);
      randomCoeffs(m);
      applyStimulus(m);
      repeat (50) @(negedge clk);
      checkOutput("stall_ack_total", sumAcks() - acks_before, 5);
      checkOutput("stall_hit_count", hit_count, hits_before + 5);
      checkOutput("stall_tx_valid", tx_valid, 1);
      ready_mode = 1;
      waitDrain("stall", 400);
      checkIdle("stall");
      releaseAll();

      $display("[TB] random rounds with random readiness");
      ready_mode = 2;
      for (int r = 0; r < 20; r++) begin
         m = randomMask($urandom_range(1, 4));
         randomCoeffs(m);
         applyStimulus(m);
         waitDrain("random", 500);
         checkIdle("random");
         releaseAll();
      end

      $display("[TB] reset in the middle of a record");
      ready_mode = 1;
      repeat (2) @(negedge clk);
      m = randomMask(1);
      randomCoeffs(m);
      base = rx_bytes;
      applyStimulus(m);
      c = 0;
      while (rx_bytes < base + 2 && c < 200) begin
         @(negedge clk);
         #1;
         c++;
      end
      checkOutput("reset_mid_bytes_before", rx_bytes - base, 2);
      ready_mode = 0;
      @(negedge clk);
      checkOutput("reset_mid_pre_valid", tx_valid, 1);
      quiet = 1'b1;
      res   = 1'b1;
      found = '0;
      exp_q.delete();
      @(negedge clk);
      checkOutput("reset_mid_tx_valid", tx_valid, 0);
      checkOutput("reset_mid_hit_count", hit_count, 0);
      checkOutput("reset_mid_busy", busy, 0);
      checkOutput("reset_mid_ack", ack, 0);
      res = 1'b0;
      model_hits = 0;
      for (int i = 0; i < N; i++) begin
         ack_exp[i]  = 0;
         ack_seen[i] = 0;
      end
      repeat (2) @(negedge clk);
      quiet      = 1'b0;
      ready_mode = 1;
      repeat (2) @(negedge clk);

      $display("[TB] recovery after reset");
      lin_val[5] = 64'hABCDEF;
      non_val[5] = 64'h1234;
      m = '0;
      m[5] = 1'b1;
      applyStimulus(m);
      waitDrain("recover", 200);
      checkIdle("recover");
      releaseAll();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
      $finish;
   end

endmodule
